wb_stage: RTL and testbench

//   Parametrised writeback pipeline stage between the EX/MEM stage and the register file.
//   Has a valid/ready handshake with a 2-entry skid buffer, so a busy register-file port stalls cleanly.

---
 rtl/wb_pkg.sv | 40 ++++
 rtl/wb_load_align.sv | 23 ++
 rtl/wb_stage.sv | 110 +++++++++++
 tb/tb_wb_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load-mode encodings, entry
// control fields and the 32-bit load alignment helper.
package wb_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_B    = 3'd1,
    LD_BU   = 3'd2,
    LD_H    = 3'd3,
    LD_HU   = 3'd4,
    LD_W    = 3'd5
  } wb_ld_e;

  localparam int unsigned LD_MODE_W = 3;

  // Control part of a buffered entry; the width-dependent wreg/data fields are
  // appended by the stage, which knows REG_AW and DATA_W.
  typedef struct packed {
    logic v;
    logic wd;
  } wb_entry_t;

  // Little-endian load alignment for a 32-bit word; reserved codes pass through.
  function automatic logic [31:0] align32(input logic [LD_MODE_W-1:0] ld,
                                          input logic [1:0]           lo,
                                          input logic [31:0]          w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (ld)
      LD_B:    return {{24{b[7]}}, b};
      LD_BU:   return {24'h0, b};
      LD_H:    return {{16{h[15]}}, h};
      LD_HU:   return {16'h0, h};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load-data alignment and extension applied before the data
// enters the writeback skid buffer.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [LD_MODE_W-1:0] ex_ld,
  input  logic [1:0]           ex_addr_lo,
  input  logic [DATA_W-1:0]    ex_wdata,
  output logic [DATA_W-1:0]    aligned
);

  // Sub-word loads only exist on the 32-bit datapath; other widths pass through.
  generate
    if (DATA_W == 32) begin : g_w32
      assign aligned = align32(ex_ld, ex_addr_lo, ex_wdata);
    end else begin : g_pass
      assign aligned = ex_wdata;
    end
  endgenerate

endmodule

// File: rtl/wb_stage.sv
// Writeback pipeline stage: 2-entry skid buffer (main M, skid S) between
// EX/MEM and the register file, with flush and a bypass view of M.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter bit ZERO_DISCARD = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 ex_wd,
  input  logic [REG_AW-1:0]    ex_wreg,
  input  logic [DATA_W-1:0]    ex_wdata,
  input  logic [LD_MODE_W-1:0] ex_ld,
  input  logic [1:0]           ex_addr_lo,
  input  logic                 out_ready,
  output logic                 wb_wd,
  output logic [REG_AW-1:0]    wb_wreg,
  output logic [DATA_W-1:0]    wb_wdata,
  output logic                 fwd_valid,
  output logic [REG_AW-1:0]    fwd_wreg,
  output logic [DATA_W-1:0]    fwd_wdata
);

  typedef struct packed {
    wb_entry_t         ctl;
    logic [REG_AW-1:0] wreg;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t m_q, m_n;
  entry_t s_q, s_n;
  entry_t in_entry;
  logic   in_ready_q;
  logic   push;
  logic   pop;
  logic   m_write;
  logic [DATA_W-1:0] aligned;

  wb_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .ex_ld      (ex_ld),
    .ex_addr_lo (ex_addr_lo),
    .ex_wdata   (ex_wdata),
    .aligned    (aligned)
  );

  // A write to register 0 is turned into a bubble when ZERO_DISCARD is set.
  always_comb begin
    in_entry.ctl.v  = 1'b1;
    in_entry.ctl.wd = ex_wd & ~(ZERO_DISCARD && (ex_wreg == '0));
    in_entry.wreg   = ex_wreg;
    in_entry.data   = aligned;
  end

  assign push = in_valid & in_ready_q;
  assign pop  = m_q.ctl.v & out_ready;

  // NOTE: every variable gets its hold value first, so no path can infer a latch.
  always_comb begin
    m_n = m_q;
    s_n = s_q;
    if (flush) begin
      m_n.ctl.v = 1'b0;
      s_n.ctl.v = 1'b0;
    end else if (pop && s_q.ctl.v) begin
      m_n = s_q;
      if (push) s_n = in_entry;
      else      s_n.ctl.v = 1'b0;
    end else if (pop) begin
      if (push) m_n = in_entry;
      else      m_n.ctl.v = 1'b0;
    end else if (push) begin
      if (!m_q.ctl.v) m_n = in_entry;
      else            s_n = in_entry;
    end
  end

  // NOTE: the two entries are tiny, so payload fields are reset along with the
  // valid bits; a large buffer would reset only the valid bits.
  // NOTE: state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
    end else begin
      m_q        <= m_n;
      s_q        <= s_n;
      in_ready_q <= ~s_n.ctl.v;
    end
  end

  assign in_ready = in_ready_q;

  // Write-port view depends on out_ready; the bypass view does not.
  assign m_write   = m_q.ctl.v & m_q.ctl.wd;
  assign wb_wd     = m_write & out_ready;
  assign wb_wreg   = wb_wd ? m_q.wreg : '0;
  assign wb_wdata  = wb_wd ? m_q.data : '0;
  assign fwd_valid = m_write;
  assign fwd_wreg  = m_write ? m_q.wreg : '0;
  assign fwd_wdata = m_write ? m_q.data : '0;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a table of single-entry vectors for alignment
// and zero-register handling, plus hand-written stall, flush and reset sequences.
module tb_wb_stage;
  import wb_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        ex_wd;
  logic [4:0]  ex_wreg;
  logic [31:0] ex_wdata;
  logic [2:0]  ex_ld;
  logic [1:0]  ex_addr_lo;
  logic        out_ready;

  logic        in_ready,  in_ready0;
  logic        wb_wd,     wb_wd0;
  logic [4:0]  wb_wreg,   wb_wreg0;
  logic [31:0] wb_wdata,  wb_wdata0;
  logic        fwd_valid, fwd_valid0;
  logic [4:0]  fwd_wreg,  fwd_wreg0;
  logic [31:0] fwd_wdata, fwd_wdata0;

  int errors = 0;
  int checks = 0;

  wb_stage #(.DATA_W(32), .REG_AW(5), .ZERO_DISCARD(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_ld(ex_ld),
    .ex_addr_lo(ex_addr_lo), .out_ready(out_ready), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
    .wb_wdata(wb_wdata), .fwd_valid(fwd_valid), .fwd_wreg(fwd_wreg), .fwd_wdata(fwd_wdata)
  );

  wb_stage #(.DATA_W(32), .REG_AW(5), .ZERO_DISCARD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_ld(ex_ld),
    .ex_addr_lo(ex_addr_lo), .out_ready(out_ready), .wb_wd(wb_wd0), .wb_wreg(wb_wreg0),
    .wb_wdata(wb_wdata0), .fwd_valid(fwd_valid0), .fwd_wreg(fwd_wreg0), .fwd_wdata(fwd_wdata0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ld;
    logic [1:0]  lo;
    logic [31:0] wdata;
    logic        wd;
    logic [4:0]  wreg;
    logic [31:0] aligned;
    logic        exp_wd;   // ZERO_DISCARD=1
    logic        exp_wd0;  // ZERO_DISCARD=0
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wd, input logic [4:0] wreg, input logic [31:0] data,
                       input logic [2:0] ld, input logic [1:0] lo);
    in_valid   = 1'b1;
    ex_wd      = wd;
    ex_wreg    = wreg;
    ex_wdata   = data;
    ex_ld      = ld;
    ex_addr_lo = lo;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_wb_wd"},     32'(wb_wd),     32'h0);
    check({tag, "_wb_wreg"},   32'(wb_wreg),   32'h0);
    check({tag, "_wb_wdata"},  wb_wdata,       32'h0);
    check({tag, "_fwd_valid"}, 32'(fwd_valid), 32'h0);
    check({tag, "_fwd_wreg"},  32'(fwd_wreg),  32'h0);
    check({tag, "_fwd_wdata"}, fwd_wdata,      32'h0);
    check({tag, "_in_ready"},  32'(in_ready),  32'h1);
  endtask

  initial begin
    vecs[0]  = '{3'(LD_NONE), 2'd0, 32'h0000_1234, 1'b1, 5'd3,  32'h0000_1234, 1'b1, 1'b1};
    vecs[1]  = '{3'(LD_B),    2'd0, 32'h80FF_7F01, 1'b1, 5'd5,  32'h0000_0001, 1'b1, 1'b1};
    vecs[2]  = '{3'(LD_B),    2'd1, 32'h80FF_7F01, 1'b1, 5'd5,  32'h0000_007F, 1'b1, 1'b1};
    vecs[3]  = '{3'(LD_B),    2'd2, 32'h80FF_7F01, 1'b1, 5'd5,  32'hFFFF_FFFF, 1'b1, 1'b1};
    vecs[4]  = '{3'(LD_B),    2'd3, 32'h80FF_7F01, 1'b1, 5'd5,  32'hFFFF_FF80, 1'b1, 1'b1};
    vecs[5]  = '{3'(LD_HU),   2'd2, 32'h80FF_7F01, 1'b1, 5'd6,  32'h0000_80FF, 1'b1, 1'b1};
    vecs[6]  = '{3'(LD_BU),   2'd3, 32'h80FF_7F01, 1'b1, 5'd7,  32'h0000_0080, 1'b1, 1'b1};
    vecs[7]  = '{3'(LD_H),    2'd0, 32'h80FF_7F01, 1'b1, 5'd8,  32'h0000_7F01, 1'b1, 1'b1};
    vecs[8]  = '{3'(LD_H),    2'd3, 32'h80FF_7F01, 1'b1, 5'd8,  32'hFFFF_80FF, 1'b1, 1'b1};
    vecs[9]  = '{3'(LD_HU),   2'd1, 32'h80FF_7F01, 1'b1, 5'd9,  32'h0000_7F01, 1'b1, 1'b1};
    vecs[10] = '{3'(LD_W),    2'd2, 32'h80FF_7F01, 1'b1, 5'd10, 32'h80FF_7F01, 1'b1, 1'b1};
    vecs[11] = '{3'd7,        2'd1, 32'h80FF_7F01, 1'b1, 5'd11, 32'h80FF_7F01, 1'b1, 1'b1};
    vecs[12] = '{3'(LD_NONE), 2'd0, 32'h0000_0055, 1'b0, 5'd12, 32'h0000_0055, 1'b0, 1'b0};
    vecs[13] = '{3'(LD_NONE), 2'd0, 32'h0000_DEAD, 1'b1, 5'd0,  32'h0000_DEAD, 1'b0, 1'b1};

    // Reset with live inputs: everything must stay quiet.
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 5'd3, 32'h1234, 3'(LD_NONE), 2'd0);
    #12;
    check_idle("reset");
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Table: push each vector with out_ready high; it is visible one cycle later.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].wd, vecs[i].wreg, vecs[i].wdata, vecs[i].ld, vecs[i].lo);
      tick();
      in_valid = 1'b0;
      #1;
      check($sformatf("v%0d_wb_wd", i),    32'(wb_wd),     32'(vecs[i].exp_wd));
      check($sformatf("v%0d_wb_wreg", i),  32'(wb_wreg),   vecs[i].exp_wd ? 32'(vecs[i].wreg) : 32'h0);
      check($sformatf("v%0d_wb_wdata", i), wb_wdata,       vecs[i].exp_wd ? vecs[i].aligned : 32'h0);
      check($sformatf("v%0d_fwd_valid", i), 32'(fwd_valid), 32'(vecs[i].exp_wd));
      check($sformatf("v%0d_zd0_wb_wd", i), 32'(wb_wd0),    32'(vecs[i].exp_wd0));
      check($sformatf("v%0d_zd0_wdata", i), wb_wdata0,      vecs[i].exp_wd0 ? vecs[i].aligned : 32'h0);
    end
    tick();
    check("drain_wb_wd", 32'(wb_wd), 32'h0);
    check("drain_in_ready", 32'(in_ready), 32'h1);

    // Stall: A then B with out_ready low fills M and S.
    out_ready = 1'b0;
    drive(1'b1, 5'd10, 32'hAAAA, 3'(LD_NONE), 2'd0);
    tick();
    drive(1'b1, 5'd11, 32'hBBBB, 3'(LD_NONE), 2'd0);
    tick();
    drive(1'b1, 5'd20, 32'hCCCC, 3'(LD_NONE), 2'd0);  // must be ignored: in_ready=0
    #1;
    check("stall_in_ready", 32'(in_ready), 32'h0);
    check("stall_fwd_valid", 32'(fwd_valid), 32'h1);
    check("stall_fwd_wreg", 32'(fwd_wreg), 32'd10);
    check("stall_fwd_wdata", fwd_wdata, 32'hAAAA);
    check("stall_wb_wd", 32'(wb_wd), 32'h0);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("stall_a_wb_wd", 32'(wb_wd), 32'h1);
    check("stall_a_wreg", 32'(wb_wreg), 32'd10);
    check("stall_a_wdata", wb_wdata, 32'hAAAA);
    tick();
    check("stall_b_wd", 32'(wb_wd), 32'h1);
    check("stall_b_wreg", 32'(wb_wreg), 32'd11);
    check("stall_b_wdata", wb_wdata, 32'hBBBB);
    check("stall_b_in_ready", 32'(in_ready), 32'h1);
    tick();
    check("stall_done_wd", 32'(wb_wd), 32'h0);
    check("stall_done_fwd", 32'(fwd_valid), 32'h0);

    // Flush with both entries full, plus a concurrent push and pop.
    out_ready = 1'b0;
    drive(1'b1, 5'd12, 32'h1111, 3'(LD_NONE), 2'd0);
    tick();
    drive(1'b1, 5'd13, 32'h2222, 3'(LD_NONE), 2'd0);
    tick();
    drive(1'b1, 5'd14, 32'h3333, 3'(LD_NONE), 2'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    check("flush_cycle_wd", 32'(wb_wd), 32'h1);
    check("flush_cycle_wreg", 32'(wb_wreg), 32'd12);
    check("flush_cycle_wdata", wb_wdata, 32'h1111);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check_idle("flush_after");
    tick();
    check("flush_later_wd", 32'(wb_wd), 32'h0);

    // Asynchronous reset between edges while full.
    out_ready = 1'b0;
    drive(1'b1, 5'd15, 32'h4444, 3'(LD_NONE), 2'd0);
    tick();
    drive(1'b1, 5'd16, 32'h5555, 3'(LD_NONE), 2'd0);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("prerst_wd", 32'(wb_wd), 32'h1);
    check("prerst_in_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_idle("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
